// File: rtl/mod_counter.sv
// mod_counter
//
// Parametrised up/down modulo counter with a programmable terminal value.
// The count range is 0..max_val. Counting up, the terminal is max_val and
// the start value is 0. Counting down, the terminal is 0 and the start
// value is max_val.
//
// Control priority, highest first: rst > clear > load > en.
//
// End-of-range behaviour is selected by mode:
//   00 / 11  wrap      - return to the start value and pulse wrap
//   01       saturate  - stick at the terminal
//   10       one-shot  - stick at the terminal and halt until clear/load/rst
//
// Ports:
//   clk       in          rising-edge clock
//   rst       in          asynchronous active-high reset
//   clear     in          synchronous clear to 0
//   load      in          synchronous load of min(load_val, max_val)
//   load_val  in  WIDTH   value for load
//   en        in          count enable, one step per cycle
//   up        in          direction, 1 = increment, 0 = decrement
//   mode      in  2       end-of-range mode (see above)
//   max_val   in  WIDTH   upper bound of the count range
//   count     out WIDTH   registered count
//   wrap      out         registered pulse, a wrap happened on the last edge
//   done      out         registered, one-shot has halted
//   at_term   out         combinational, count equals the current terminal
//   carry     out         combinational cascade enable for the next stage
module mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done,
    output logic             at_term,
    output logic             carry
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] count_r;
    logic             wrap_r;

    logic             wrap_mode_s;
    logic             oneshot_s;
    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] start_s;
    logic             at_term_s;
    logic             past_end_s;
    logic [WIDTH-1:0] stepped_s;
    logic [WIDTH-1:0] load_sat_s;
    logic             halted_s;
    logic             step_s;

    // Decode of mode/direction and the values each step can produce.
    always_comb begin
        wrap_mode_s = (mode == 2'b00) || (mode == 2'b11);
        oneshot_s   = (mode == 2'b10);
        term_s      = up ? max_val : {WIDTH{1'b0}};
        start_s     = up ? {WIDTH{1'b0}} : max_val;
        at_term_s   = (count_r == term_s);
        // Counting up, a count above max_val (after max_val was lowered at
        // runtime) is handled exactly like sitting on the terminal.
        past_end_s  = up ? (count_r >= max_val) : (count_r == {WIDTH{1'b0}});
        stepped_s   = up ? (count_r + WIDTH'(1)) : (count_r - WIDTH'(1));
        load_sat_s  = (load_val > max_val) ? max_val : load_val;
        // HALT only blocks stepping while still in one-shot; leaving one-shot
        // lets the counter step on the same edge the FSM returns to RUN.
        halted_s    = (state_r == HALT) && oneshot_s;
        step_s      = en && !halted_s;
    end

    // Count, wrap pulse and one-shot FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            state_r <= RUN;
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            state_r <= RUN;
        end else if (load) begin
            count_r <= load_sat_s;
            wrap_r  <= 1'b0;
            state_r <= RUN;
        end else begin
            wrap_r <= 1'b0;
            if (!oneshot_s) begin
                state_r <= RUN;
            end
            if (step_s) begin
                if (past_end_s) begin
                    if (wrap_mode_s) begin
                        count_r <= start_s;
                        wrap_r  <= 1'b1;
                    end else begin
                        // Saturate and one-shot both stick at the terminal.
                        count_r <= term_s;
                        if (oneshot_s) begin
                            state_r <= HALT;
                        end
                    end
                end else begin
                    count_r <= stepped_s;
                    if (oneshot_s && (stepped_s == term_s)) begin
                        state_r <= HALT;
                    end
                end
            end
        end
    end

    assign count   = count_r;
    assign wrap    = wrap_r;
    assign done    = (state_r == HALT);
    assign at_term = at_term_s;
    assign carry   = en && at_term_s && wrap_mode_s && !clear && !load;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH = 8): a table of directed
// vectors with hand-computed expected outputs, plus hand-written sequences
// for asynchronous reset mid-count and in HALT.
module tb_mod_counter;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       up;
    logic [1:0] mode;
    logic [7:0] max_val;
    logic [7:0] count;
    logic       wrap;
    logic       done;
    logic       at_term;
    logic       carry;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       clear;
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic       up;
        logic [1:0] mode;
        logic [7:0] max_val;
        logic [7:0] e_count;
        logic       e_wrap;
        logic       e_done;
        logic       e_at_term;
        logic       e_carry;
    } vec_t;

    vec_t vecs[$];

    mod_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .max_val  (max_val),
        .count    (count),
        .wrap     (wrap),
        .done     (done),
        .at_term  (at_term),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic l, input logic [7:0] lv,
                                input logic e, input logic u, input logic [1:0] m,
                                input logic [7:0] mx, input logic [7:0] ec,
                                input logic ew, input logic ed, input logic et,
                                input logic eca);
        vec_t v;
        v.clear = c; v.load = l; v.load_val = lv; v.en = e; v.up = u;
        v.mode = m; v.max_val = mx; v.e_count = ec; v.e_wrap = ew;
        v.e_done = ed; v.e_at_term = et; v.e_carry = eca;
        return v;
    endfunction

    // Packs {count, wrap, done, at_term, carry} into 12 bits and compares.
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got count=%0d wrap=%b done=%b at_term=%b carry=%b, want count=%0d wrap=%b done=%b at_term=%b carry=%b",
                     name, act[11:4], act[3], act[2], act[1], act[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] outs();
        return {count, wrap, done, at_term, carry};
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'd0; en = 1'b0;
        up = 1'b1; mode = 2'b00; max_val = 8'd5;

        //            clr  ld   lval    en   up   mode   max     count   wr   dn   at   cy
        // Up count, wrap mode, max 5: 1..5 then wrap to 0.
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd1,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd2,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd3,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd4,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd5,  1'b0,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd0,  1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd5,  8'd1,  1'b0,1'b0,1'b0,1'b0));
        // Down, saturate, max 9, load 3: 3,2,1,0,0,0.
        vecs.push_back(mk(1'b0,1'b1,8'd3,  1'b0,1'b0,2'b01,8'd9,  8'd3,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b01,8'd9,  8'd2,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b01,8'd9,  8'd1,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b01,8'd9,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b01,8'd9,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b01,8'd9,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        // One-shot up, max 3, from clear; halts with 3, load 1 restarts.
        vecs.push_back(mk(1'b1,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd3,  8'd0,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd3,  8'd1,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd3,  8'd2,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd3,  8'd3,  1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd3,  8'd3,  1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,8'd1,  1'b0,1'b1,2'b10,8'd3,  8'd1,  1'b0,1'b0,1'b0,1'b0));
        // Priority: clear beats load and en; load clamps to max_val.
        vecs.push_back(mk(1'b0,1'b1,8'd4,  1'b0,1'b1,2'b00,8'd9,  8'd4,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,8'd7,  1'b1,1'b1,2'b00,8'd9,  8'd0,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,8'd200,1'b1,1'b1,2'b00,8'd10, 8'd10, 1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd10, 8'd0,  1'b1,1'b0,1'b0,1'b0));
        // Runtime max_val drop 15 -> 4 at count 9: wrap mode, then saturate.
        vecs.push_back(mk(1'b0,1'b1,8'd9,  1'b0,1'b1,2'b00,8'd15, 8'd9,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd4,  8'd0,  1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,8'd9,  1'b0,1'b1,2'b01,8'd15, 8'd9,  1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b01,8'd4,  8'd4,  1'b0,1'b0,1'b1,1'b0));
        // max_val = 0: wrap every enabled cycle in both directions.
        vecs.push_back(mk(1'b1,1'b0,8'd0,  1'b0,1'b1,2'b00,8'd0,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b00,8'd0,  8'd0,  1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b00,8'd0,  8'd0,  1'b1,1'b0,1'b1,1'b1));
        // max_val = 0, one-shot: halts on the first enabled cycle.
        vecs.push_back(mk(1'b1,1'b0,8'd0,  1'b0,1'b1,2'b10,8'd0,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b1,2'b10,8'd0,  8'd0,  1'b0,1'b1,1'b1,1'b0));
        // Down count, wrap mode: 0 wraps to max_val.
        vecs.push_back(mk(1'b0,1'b1,8'd0,  1'b0,1'b0,2'b00,8'd5,  8'd0,  1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,8'd0,  1'b1,1'b0,2'b00,8'd5,  8'd5,  1'b1,1'b0,1'b0,1'b0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear    = vecs[i].clear;
            load     = vecs[i].load;
            load_val = vecs[i].load_val;
            en       = vecs[i].en;
            up       = vecs[i].up;
            mode     = vecs[i].mode;
            max_val  = vecs[i].max_val;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_count, vecs[i].e_wrap, vecs[i].e_done,
                   vecs[i].e_at_term, vecs[i].e_carry});
        end

        // Asynchronous reset mid-count.
        @(negedge clk);
        clear = 1'b0; load = 1'b1; load_val = 8'd2; en = 1'b0;
        up = 1'b1; mode = 2'b00; max_val = 8'd5;
        @(posedge clk);
        #1;
        check("pre_rst_load", outs(), {8'd2, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_midcount", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_after_rst", outs(), {8'd1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset while halted.
        @(negedge clk);
        clear = 1'b1; en = 1'b0; mode = 2'b10; max_val = 8'd3;
        @(negedge clk);
        clear = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("halted", outs(), {8'd3, 1'b0, 1'b1, 1'b1, 1'b0});
        #1;
        rst = 1'b1;
        #1;
        check("rst_in_halt", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_after_halt_rst", outs(), {8'd1, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
